// File: rtl/mux4t1_arbiter.sv
//------------------------------------------------------------------------------
// Module  : mux4t1_arbiter
// Brief   : Round-robin grant/select controller for a 4:1 WIDTH-bit mux with a
//           registered, valid-qualified output word. Optional beat-limit
//           forced release enabled by defining MUXARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux4t1_arbiter #(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [3:0]       last,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
  output logic [3:0]       gnt,
  output logic [1:0]       s,
  output logic [WIDTH-1:0] o,
  output logic             o_valid,
  output logic             busy,
  output logic             timeout
);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_ptr, w_ptr_nxt;
  logic [1:0]       r_s, w_s_nxt;
  logic [3:0]       r_gnt, w_gnt_nxt;
  logic [WIDTH-1:0] r_o;
  logic             r_o_valid, r_busy, r_timeout;

  logic [1:0]       w_arb_base, w_off, w_winner;
  logic [3:0]       w_rot;
  logic [WIDTH-1:0] w_data_k;
  logic             w_beat, w_final, w_to_hit, w_release;

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 1..255");
  end

  // A releasing grant re-arbitrates from k+1 on the same edge, so the
  // releasing index naturally becomes lowest priority.
  assign w_arb_base = (r_state == GRANT) ? (r_s + 2'd1) : r_ptr;

  always_comb begin
    w_rot = req;
    case (w_arb_base)
      2'd0: w_rot = req;
      2'd1: w_rot = {req[0],   req[3:1]};
      2'd2: w_rot = {req[1:0], req[3:2]};
      2'd3: w_rot = {req[2:0], req[3]};
      default: w_rot = req;
    endcase
  end

  always_comb begin
    w_off = 2'd3;
    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else if (w_rot[2]) w_off = 2'd2;
  end

  assign w_winner = w_arb_base + w_off;

  always_comb begin
    w_data_k = I0;
    case (r_s)
      2'd0: w_data_k = I0;
      2'd1: w_data_k = I1;
      2'd2: w_data_k = I2;
      2'd3: w_data_k = I3;
      default: w_data_k = I0;
    endcase
  end

  assign w_beat  = (r_state == GRANT) && req[r_s];
  assign w_final = w_beat && last[r_s];

`ifdef MUXARB_TIMEOUT_EN
  localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);
  logic [7:0] r_cnt;

  // A last on the limit beat is an ordinary release, so it masks the timeout.
  assign w_to_hit = w_beat && !last[r_s] && (r_cnt == c_hold_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if ((r_state == IDLE) || w_release) begin
      r_cnt <= 8'd0;
    end else if (w_beat) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end
`else
  assign w_to_hit = 1'b0;
`endif

  assign w_release = (r_state == GRANT) && (!req[r_s] || w_final || w_to_hit);

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_s_nxt     = r_s;
    w_ptr_nxt   = r_ptr;
    if ((r_state == IDLE) || w_release) begin
      if (r_state == GRANT) begin
        w_ptr_nxt = r_s + 2'd1;
      end
      if (|req) begin
        w_state_nxt = GRANT;
        w_gnt_nxt   = 4'b0001 << w_winner;
        w_s_nxt     = w_winner;
      end else begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = 4'b0000;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= 2'd0;
      r_s       <= 2'd0;
      r_gnt     <= 4'b0000;
      r_o       <= '0;
      r_o_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_s       <= w_s_nxt;
      r_gnt     <= w_gnt_nxt;
      r_o_valid <= w_beat;
      r_busy    <= (w_state_nxt == GRANT);
      r_timeout <= w_to_hit;
      if (w_beat) begin
        r_o <= w_data_k;
      end
    end
  end

  assign gnt     = r_gnt;
  assign s       = r_s;
  assign o       = r_o;
  assign o_valid = r_o_valid;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_mux4t1_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_mux4t1_arbiter
// Brief   : Self-checking bench for mux4t1_arbiter against a behavioural model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux4t1_arbiter;

  localparam int W  = 4;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req = 4'b0;
  logic [3:0]   last = 4'b0;
  logic [W-1:0] I0 = '0, I1 = '0, I2 = '0, I3 = '0;
  logic [3:0]   gnt;
  logic [1:0]   s;
  logic [W-1:0] o;
  logic         o_valid, busy, timeout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux4t1_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last),
    .I0(I0), .I1(I1), .I2(I2), .I3(I3),
    .gnt(gnt), .s(s), .o(o), .o_valid(o_valid), .busy(busy), .timeout(timeout)
  );

  // Behavioural model: granted index (-1 = idle), pointer, beat count.
  int           m_g = -1, m_ptr = 0, m_cnt = 0, m_s = 0;
  logic [W-1:0] m_o = '0;
  bit           m_ov = 0, m_to = 0;

  function automatic int pick(int p);
    for (int i = 0; i < 4; i++)
      if (req[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  function automatic logic [W-1:0] word(int k);
    case (k)
      0: return I0;
      1: return I1;
      2: return I2;
      default: return I3;
    endcase
  endfunction

  task automatic model_reset();
    m_g = -1; m_ptr = 0; m_cnt = 0; m_s = 0; m_o = '0; m_ov = 0; m_to = 0;
  endtask

  task automatic model_step();
    int  w;
    int  k;
    bit  rel;
    m_ov = 0; m_to = 0; rel = 0;
    if (m_g < 0) begin
      w = pick(m_ptr);
      if (w >= 0) begin m_g = w; m_s = w; m_cnt = 0; end
    end else begin
      k = m_g;
      if (req[k]) begin
        m_o = word(k); m_ov = 1; m_cnt++;
        if (last[k]) rel = 1;
`ifdef MUXARB_TIMEOUT_EN
        else if (m_cnt == MH) begin rel = 1; m_to = 1; end
`endif
      end else begin
        rel = 1;
      end
      if (rel) begin
        m_ptr = (k + 1) % 4;
        m_cnt = 0;
        w = pick(m_ptr);
        if (w >= 0) begin m_g = w; m_s = w; end
        else m_g = -1;
      end
    end
  endtask

  function automatic logic [12:0] exp_vec();
    logic [3:0] g;
    g = (m_g < 0) ? 4'b0000 : 4'(1 << m_g);
    return {g, 2'(m_s), m_o, m_ov, (m_g >= 0), m_to};
  endfunction

  logic [12:0] dut_vec;
  assign dut_vec = {gnt, s, o, o_valid, busy, timeout};

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req = 4'b0; last = 4'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_data();
    I0 = W'($urandom); I1 = W'($urandom); I2 = W'($urandom); I3 = W'($urandom);
  endtask

  task automatic test_reset();
    apply_reset();
    rand_data();
    req = 4'b1111; last = 4'b0000;
    tick();
    n_cmp++;
    if (gnt !== 4'b0001) begin n_err++; $display("FAIL reset_first_grant: got %b want 0001", gnt); end
    tick();
    n_cmp++;
    if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL reset_pre_beat: got %h want %h", dut_vec, exp_vec()); end
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (dut_vec !== 13'h0) begin n_err++; $display("FAIL reset_async_clear: got %h want 0000", dut_vec); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (gnt !== 4'b0001 || s !== 2'd0) begin
      n_err++; $display("FAIL reset_regrant: got gnt=%b s=%0d want 0001/0", gnt, s);
    end
    req = 4'b0;
    tick();
  endtask

  task automatic test_single();
    int nv;
    apply_reset();
    rand_data();
    I2 = 4'h4;
    req = 4'b0100; last = 4'b0000;
    tick();
    n_cmp++;
    if (gnt !== 4'b0100 || s !== 2'd2 || o_valid !== 1'b0) begin
      n_err++; $display("FAIL single_grant: got gnt=%b s=%0d v=%b want 0100/2/0", gnt, s, o_valid);
    end
    nv = 0;
    for (int b = 1; b <= 4; b++) begin
      last = (b == 3) ? 4'b0100 : 4'b0000;
      if (b == 4) req = 4'b0000;
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL single_beat%0d: got %h want %h", b, dut_vec, exp_vec()); end
      if (o_valid === 1'b1 && o === 4'h4) nv++;
    end
    tick();
    n_cmp++;
    if (nv !== 3 || gnt !== 4'b0000 || busy !== 1'b0) begin
      n_err++; $display("FAIL single_end: got beats=%0d gnt=%b busy=%b want 3/0000/0", nv, gnt, busy);
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    req = 4'b1111; last = 4'b1111;
    rand_data();
    tick();
    n_cmp++;
    if (gnt !== 4'b0001 || s !== 2'd0) begin n_err++; $display("FAIL rr_first: got gnt=%b s=%0d want 0001/0", gnt, s); end
    for (int i = 1; i < 5; i++) begin
      rand_data();
      tick();
      n_cmp++;
      if (gnt !== 4'(1 << order[i]) || s !== 2'(order[i]) || o_valid !== 1'b1) begin
        n_err++; $display("FAIL rr_step%0d: got gnt=%b s=%0d v=%b want idx %0d valid", i, gnt, s, o_valid, order[i]);
      end
      n_cmp++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL rr_model%0d: got %h want %h", i, dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_abandon();
    apply_reset();
    rand_data();
    req = 4'b0010; last = 4'b0000;
    tick();
    req = 4'b1011;
    tick();
    n_cmp++;
    if (gnt !== 4'b0010 || o_valid !== 1'b1 || o !== I1) begin
      n_err++; $display("FAIL abandon_hold: got gnt=%b v=%b o=%h want 0010/1/%h", gnt, o_valid, o, I1);
    end
    req = 4'b1001;
    tick();
    n_cmp++;
    if (gnt !== 4'b1000 || o_valid !== 1'b0 || s !== 2'd3) begin
      n_err++; $display("FAIL abandon_move: got gnt=%b v=%b s=%0d want 1000/0/3", gnt, o_valid, s);
    end
    last = 4'b1000;
    tick();
    n_cmp++;
    if (gnt !== 4'b0001 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL abandon_wrap: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    rand_data();
    req = 4'b0011; last = 4'b0000;
    tick();
`ifdef MUXARB_TIMEOUT_EN
    for (int b = 1; b <= MH; b++) begin
      tick();
      n_cmp++;
      if (o_valid !== 1'b1 || timeout !== (b == MH) || gnt !== ((b == MH) ? 4'b0010 : 4'b0001)) begin
        n_err++; $display("FAIL timeout_beat%0d: got v=%b to=%b gnt=%b", b, o_valid, timeout, gnt);
      end
    end
    tick();
    n_cmp++;
    if (timeout !== 1'b0 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL timeout_pulse_end: got %h want %h", dut_vec, exp_vec());
    end
`else
    for (int c = 0; c < 110; c++) begin
      tick();
      n_cmp++;
      if (gnt !== 4'b0001 || timeout !== 1'b0 || dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL hold_cycle%0d: got %h want %h", c, dut_vec, exp_vec());
      end
    end
`endif
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      rand_data();
      for (int b = 0; b < 4; b++) begin
        req[b]  = ($urandom_range(0, 99) < 80);
        last[b] = ($urandom_range(0, 99) < 30);
      end
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL random_cycle%0d: got %h want %h", c, dut_vec, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_abandon();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux4t1_arbiter.md
# mux4t1_arbiter

Round-robin controller that shares the 4-way, WIDTH-bit multiplexer datapath among four requesters. It accepts per-requester request/last handshakes and drives the one-hot grant and the 2-bit mux select. It also produces a registered, valid-qualified copy of the selected input word. It sits directly in front of the 4:1 mux and owns its select lines; downstream logic consumes `o`/`o_valid`.

## Interface
- `WIDTH`, 4: data width of each input word and of `o`.
- `MAX_HOLD`, 8: maximum beats per grant. Used only when `MUXARB_TIMEOUT_EN` is defined. Legal range 1..255.

- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req` input 4: req[i] high means requester i wants the datapath; held until granted and through its transfer.
- `last` input 4: last[i] marks the final beat of requester i's transfer; sampled only while gnt[i] is high.
- `I0`..`I3` input WIDTH each: requester data words.
- `gnt` output 4: one-hot grant, registered; all-zero when idle.
- `s` output 2: mux select, registered, equals index of the granted requester; holds the last value when idle.
- `o` output WIDTH: registered data, I[s] captured on each granted beat.
- `o_valid` output 1: high for one cycle per captured beat.
- `busy` output 1: high while any grant is active.
- `timeout` output 1: one-cycle pulse on a forced release; constant 0 without the macro.

## Operation
- States: IDLE, GRANT.
- Round-robin pointer `ptr` (2 bits) is the highest-priority index. Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE: if req != 0, the first requesting index in search order wins. On that edge: gnt = one-hot(winner), s = winner, go to GRANT. Otherwise stay idle; gnt = 0.
- GRANT, each cycle, call the granted index k = s. A beat occurs when req[k] is high.
- On each beat: o <= I[k], o_valid <= 1.
- With no beat: o_valid <= 0 and o holds.
- Release happens on an edge where:
  - req[k] and last[k] are both high (final beat, which is still captured), or
  - req[k] is low (abandon, no beat).
- On release: ptr <= k+1 mod 4, and re-arbitrate on the same edge using the updated pointer.
  - If any req is high, the next winner is granted with no idle cycle. A requester still asserting req after its own last is regranted only if no other requester is asserting req.
  - Otherwise go to IDLE, gnt = 0.
- While in GRANT, gnt and s never change except at a release edge. Requests from other indices are ignored until then.
- last[i] with gnt[i] low is ignored.
- busy = (state == GRANT), registered together with gnt.

## Timing
- Reset values: gnt=0, s=0, o=0, o_valid=0, busy=0, timeout=0, ptr=0, state IDLE, beat counter 0.
- Asserting rst_n low mid-transfer clears all state immediately (asynchronously). The in-flight transfer is dropped with no o_valid for it.
- Request to grant latency: 1 cycle. The first beat is captured at the edge after gnt rises, provided req is still high.
- Data latency: o/o_valid lag the granted I[k] by 1 cycle.
- Back-to-back handover: the gnt change is coincident with the final-beat capture edge. There is no bubble on o_valid when the next requester holds req.
- Pointer wrap: after releasing index 3, ptr = 0.

## Configuration
- `MUXARB_TIMEOUT_EN` defined:
  - An 8-bit beat counter counts beats of the current grant and clears on every grant/release.
  - When the counter reaches MAX_HOLD beats without a last, the MAX_HOLD-th beat edge is treated as a release: the beat is captured, timeout pulses high for 1 cycle, and the pointer advances as usual.
  - last and the timeout on the same edge count as a normal release; timeout stays 0.
- Not defined: no counter; a grant is held indefinitely until last or req drops; timeout tied 0.

## Test plan
- Reset: assert rst_n=0 mid-GRANT -> gnt=0, s=0, o=0, o_valid=0, busy=0 immediately; first grant after release of reset goes to index 0 when req=4'b1111.
- Single requester: req=4'b0100, I2=4'h4, last[2] on the 3rd beat -> gnt=4'b0100 and s=2 one cycle later, 3 o_valid pulses with o=4'h4, then gnt=0, busy=0.
- Round-robin: req=4'b1111 held, each transfer 1 beat with last -> grant order 0,1,2,3,0; s follows 0,1,2,3,0; o_valid continuously high after the first grant.
- Abandon: granted index 1 drops req before last, req[3]=1 -> no beat that cycle, gnt moves to 4'b1000 on the same edge, ptr=2.
- Timeout (macro on, MAX_HOLD=4): req[0]=1 with last never asserted, req[1]=1 -> exactly 4 beats from index 0, timeout pulse, then gnt=4'b0010.
- No macro, same stimulus -> index 0 keeps the grant for 100+ cycles, timeout stays 0.
